// File: rtl/dmem_bus_master_pkg.sv
// rtl/dmem_bus_master_pkg.sv - shared constants, state type and store/align helpers for the data-memory master
package dmem_bus_master_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_DONE
    } state_t;

    // Halfwords need an even address, words a 4-byte aligned one; bytes never trap.
    function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            F3_H, F3_HU: return a[0];
            F3_W:        return (a != 2'b00);
            default:     return 1'b0;
        endcase
    endfunction

    // Byte strobes for a store; unknown widths fall back to a full word.
    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] lane);
        case (f3)
            F3_B:    return 4'b0001 << lane;
            F3_H:    return 4'b0011 << lane;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate the right-aligned store data across every lane it could land in.
    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            F3_B:    return {4{d[7:0]}};
            F3_H:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/dmem_bus_master_lsu_load_format.sv
// rtl/dmem_bus_master_lsu_load_format.sv - lane select and sign/zero extension of load data
module lsu_load_format
    import dmem_bus_master_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte/half and extend it according to the load width.
    always_comb begin
        case (lane)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data = {24'd0, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data = {16'd0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/dmem_bus_master.sv
// rtl/dmem_bus_master.sv - single-outstanding MEM-stage load/store controller on a valid/grant/rvalid bus
module dmem_bus_master #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic              mem_read_write,
    output logic              done,
    output logic              wb_reg_write,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_data,
    output logic              misaligned,
    output logic              fault,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_wstrb,
    output logic [31:0]       bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [31:0]       bus_rdata,
    input  logic              bus_err
);
    import dmem_bus_master_pkg::*;

    // The counter value seen in the last permitted REQ/RESP cycle.
    localparam logic [15:0] TMAX = 16'(TIMEOUT - 1);

    state_t      state;
    logic        is_write;
    logic [2:0]  f3;
    logic [1:0]  lane;
    logic [15:0] tcnt;
    logic        req_mis;
    logic        tmo;
    logic [31:0] fmt_data;

    assign req_mis = addr_misaligned(req_funct3, req_addr[1:0]);
    assign tmo     = (tcnt == TMAX);

    lsu_load_format u_fmt (
        .rdata  (bus_rdata),
        .lane   (lane),
        .funct3 (f3),
        .data   (fmt_data)
    );

    // Stall and misalignment decode: in IDLE these reflect the instruction sitting in EX/MEM.
    always_comb begin
        mem_read_write = 1'b0;
        misaligned     = 1'b0;
        case (state)
            S_IDLE: begin
                mem_read_write = req_valid & ~req_mis;
                misaligned     = req_valid & req_mis;
            end
            S_REQ, S_RESP: mem_read_write = 1'b1;
            default: ;
        endcase
    end

    // Access FSM with registered bus and writeback outputs; completion flags live for the DONE cycle only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            is_write     <= 1'b0;
            f3           <= 3'd0;
            lane         <= 2'd0;
            tcnt         <= 16'd0;
            done         <= 1'b0;
            fault        <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_rd        <= 5'd0;
            wb_data      <= 32'd0;
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_addr     <= '0;
            bus_wstrb    <= 4'd0;
            bus_wdata    <= 32'd0;
        end else begin
            done         <= 1'b0;
            fault        <= 1'b0;
            wb_reg_write <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid && !req_mis) begin
                        is_write  <= req_write;
                        f3        <= req_funct3;
                        lane      <= req_addr[1:0];
                        wb_rd     <= req_rd;
                        tcnt      <= 16'd0;
                        bus_req   <= 1'b1;
                        bus_we    <= req_write;
                        bus_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                        bus_wstrb <= req_write ? store_strb(req_funct3, req_addr[1:0]) : 4'd0;
                        bus_wdata <= req_write ? store_data(req_funct3, req_wdata) : 32'd0;
                        state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    tcnt <= tcnt + 16'd1;
                    if (bus_gnt && is_write) begin
                        bus_req <= 1'b0;
                        done    <= 1'b1;
                        fault   <= bus_err;
                        state   <= S_DONE;
                    end else if (tmo) begin
                        bus_req <= 1'b0;
                        done    <= 1'b1;
                        fault   <= 1'b1;
                        state   <= S_DONE;
                    end else if (bus_gnt) begin
                        bus_req <= 1'b0;
                        state   <= S_RESP;
                    end
                end
                S_RESP: begin
                    tcnt <= tcnt + 16'd1;
                    if (bus_rvalid) begin
                        wb_data      <= fmt_data;
                        done         <= 1'b1;
                        fault        <= bus_err;
                        wb_reg_write <= ~bus_err & (wb_rd != 5'd0);
                        state        <= S_DONE;
                    end else if (tmo) begin
                        done  <= 1'b1;
                        fault <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bus_master.sv
// tb/tb_dmem_bus_master.sv - directed self-checking bench for dmem_bus_master
module tb_dmem_bus_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        mem_read_write;
    logic        done;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misaligned;
    logic        fault;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        bus_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_bus_master #(.ADDR_W(32), .TIMEOUT(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_write      (req_write),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_rd         (req_rd),
        .mem_read_write (mem_read_write),
        .done           (done),
        .wb_reg_write   (wb_reg_write),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .misaligned     (misaligned),
        .fault          (fault),
        .bus_req        (bus_req),
        .bus_we         (bus_we),
        .bus_addr       (bus_addr),
        .bus_wstrb      (bus_wstrb),
        .bus_wdata      (bus_wdata),
        .bus_gnt        (bus_gnt),
        .bus_rvalid     (bus_rvalid),
        .bus_rdata      (bus_rdata),
        .bus_err        (bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load with zero-wait grant and read data; checks every cycle from issue to return to IDLE.
    task automatic run_load(input string nm, input logic [31:0] addr, input logic [2:0] f3,
                            input logic [4:0] rd, input logic [31:0] rdata,
                            input logic [31:0] exp_data, input logic exp_we);
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_funct3 = f3;
        req_addr   = addr;
        req_rd     = rd;
        bus_gnt    = 1'b1;
        bus_rvalid = 1'b1;
        bus_rdata  = rdata;
        bus_err    = 1'b0;
        #1;
        chk({nm, "_mrw_issue"}, mem_read_write, 1);
        step();
        chk({nm, "_req"}, bus_req, 1);
        chk({nm, "_we"}, bus_we, 0);
        chk({nm, "_addr"}, bus_addr, {addr[31:2], 2'b00});
        chk({nm, "_mrw_req"}, mem_read_write, 1);
        step();
        chk({nm, "_req_drop"}, bus_req, 0);
        chk({nm, "_mrw_resp"}, mem_read_write, 1);
        step();
        chk({nm, "_done"}, done, 1);
        chk({nm, "_wb_rd"}, wb_rd, rd);
        chk({nm, "_wb_data"}, wb_data, exp_data);
        chk({nm, "_wb_we"}, wb_reg_write, exp_we);
        chk({nm, "_fault"}, fault, 0);
        chk({nm, "_mrw_done"}, mem_read_write, 0);
        req_valid  = 1'b0;
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        step();
        chk({nm, "_done_clr"}, done, 0);
        chk({nm, "_we_clr"}, wb_reg_write, 0);
    endtask

    logic [2:0]  mis_f3   [3] = '{3'b010, 3'b001, 3'b101};
    logic [31:0] mis_addr [3] = '{32'h101, 32'h103, 32'h105};

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        req_rd     = 5'd0;
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = 32'd0;
        bus_err    = 1'b0;
        #12;
        chk("rst_bus_req", bus_req, 0);
        chk("rst_mrw", mem_read_write, 0);
        chk("rst_done", done, 0);
        chk("rst_wb_we", wb_reg_write, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_fault", fault, 0);
        chk("rst_mis", misaligned, 0);
        rst_n = 1'b1;
        step();

        run_load("lw",  32'h100, 3'b010, 5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 1'b1);
        run_load("lb",  32'h103, 3'b000, 5'd6,  32'h80FF0000, 32'hFFFFFF80, 1'b1);
        run_load("lbu", 32'h103, 3'b100, 5'd6,  32'h80FF0000, 32'h00000080, 1'b1);
        run_load("lh",  32'h102, 3'b001, 5'd8,  32'h80011234, 32'hFFFF8001, 1'b1);
        run_load("lhu", 32'h102, 3'b101, 5'd8,  32'h80011234, 32'h00008001, 1'b1);
        run_load("lb0", 32'h204, 3'b000, 5'd0,  32'h1122337F, 32'h0000007F, 1'b0);

        // SH to 0x202 with the grant held off for three REQ cycles.
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = 3'b001;
        req_addr   = 32'h202;
        req_wdata  = 32'h1234ABCD;
        req_rd     = 5'd0;
        #1;
        chk("sh_mrw_issue", mem_read_write, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("sh_req", bus_req, 1);
            chk("sh_we", bus_we, 1);
            chk("sh_addr", bus_addr, 32'h200);
            chk("sh_strb", bus_wstrb, 4'b1100);
            chk("sh_wdata", bus_wdata, 32'hABCDABCD);
            chk("sh_done_early", done, 0);
            chk("sh_mrw", mem_read_write, 1);
            if (i == 3) bus_gnt = 1'b1;
        end
        step();
        chk("sh_done", done, 1);
        chk("sh_wb_we", wb_reg_write, 0);
        chk("sh_fault", fault, 0);
        chk("sh_req_drop", bus_req, 0);
        chk("sh_mrw_done", mem_read_write, 0);
        req_valid = 1'b0;
        bus_gnt   = 1'b0;
        step();
        chk("sh_done_clr", done, 0);

        // SB to 0x301 with an error reported alongside the grant.
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h301;
        req_wdata  = 32'h000000AB;
        bus_gnt    = 1'b1;
        bus_err    = 1'b1;
        step();
        chk("sb_strb", bus_wstrb, 4'b0010);
        chk("sb_wdata", bus_wdata, 32'hABABABAB);
        chk("sb_addr", bus_addr, 32'h300);
        step();
        chk("sb_done", done, 1);
        chk("sb_fault", fault, 1);
        chk("sb_wb_we", wb_reg_write, 0);
        req_valid = 1'b0;
        bus_gnt   = 1'b0;
        bus_err   = 1'b0;
        step();
        chk("sb_fault_clr", fault, 0);

        // Misaligned accesses: exception in the same cycle, no stall, no bus traffic.
        for (int i = 0; i < 3; i++) begin
            req_valid  = 1'b1;
            req_write  = 1'b0;
            req_funct3 = mis_f3[i];
            req_addr   = mis_addr[i];
            bus_gnt    = 1'b1;
            #1;
            chk("mis_pulse", misaligned, 1);
            chk("mis_mrw", mem_read_write, 0);
            step();
            req_valid = 1'b0;
            #1;
            chk("mis_clr", misaligned, 0);
            chk("mis_no_req", bus_req, 0);
            chk("mis_no_done", done, 0);
            step();
            chk("mis_no_req2", bus_req, 0);
        end
        bus_gnt = 1'b0;

        // Load whose read data never arrives: eight REQ+RESP cycles then a faulting DONE.
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h40;
        req_rd     = 5'd7;
        bus_gnt    = 1'b1;
        bus_rvalid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("tmo_wait_done", done, 0);
            chk("tmo_wait_mrw", mem_read_write, 1);
        end
        step();
        chk("tmo_done", done, 1);
        chk("tmo_fault", fault, 1);
        chk("tmo_wb_we", wb_reg_write, 0);
        chk("tmo_mrw", mem_read_write, 0);
        req_valid  = 1'b0;
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h12345678;
        step();
        chk("tmo_late_done", done, 0);
        chk("tmo_late_fault", fault, 0);
        step();
        chk("tmo_late_done2", done, 0);
        chk("tmo_late_req", bus_req, 0);
        chk("tmo_late_wb_data", wb_data, 32'h0000007F);
        chk("tmo_late_wb_we", wb_reg_write, 0);
        bus_rvalid = 1'b0;
        step();

        // Reset asserted while a load waits in RESP.
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h80;
        req_rd     = 5'd3;
        bus_gnt    = 1'b1;
        step();
        chk("rr_req", bus_req, 1);
        step();
        chk("rr_in_resp", mem_read_write, 1);
        #2;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        bus_gnt   = 1'b0;
        #1;
        chk("rr_bus_req", bus_req, 0);
        chk("rr_mrw", mem_read_write, 0);
        chk("rr_done", done, 0);
        step();
        chk("rr_hold_done", done, 0);
        rst_n = 1'b1;
        step();
        chk("rr_idle_done", done, 0);
        chk("rr_idle_req", bus_req, 0);
        run_load("rr_lw", 32'h10, 3'b010, 5'd9, 32'h0BADF00D, 32'h0BADF00D, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_bus_master.md
Name: dmem_bus_master

Overview:
- Multi-cycle data-memory access controller in the MEM stage.
- Captures a load/store from EX/MEM, runs it on a valid/grant/rvalid data bus, and returns aligned, extended load data plus the destination register to the writeback mux.
- Drives `mem_read_write` to the hazard logic, which freezes PC/IF/ID/EX, flushes EX/MEM and holds MEM/WB while the access is in flight.
- Issues no speculative or pipelined bus traffic: one outstanding access.

Parameters:
- ADDR_W, 32, address width.
- TIMEOUT, 255, cycles in REQ+RESP before the access is aborted as a fault; range 1..65535.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  EX/MEM holds a load or store.
- req_write  in  1  1=store, 0=load.
- req_funct3  in  3  RISC-V width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_rd  in  5  load destination.
- mem_read_write  out  1  stall request to hazard unit.
- done  out  1  one-cycle completion pulse.
- wb_reg_write  out  1  writeback enable for load result.
- wb_rd  out  5  writeback register.
- wb_data  out  32  formatted load data.
- misaligned  out  1  one-cycle misalignment exception pulse.
- fault  out  1  one-cycle bus error/timeout pulse.
- bus_req  out  1  access request.
- bus_we  out  1  write.
- bus_addr  out  ADDR_W  word-aligned address (addr[1:0]=00).
- bus_wstrb  out  4  byte strobes.
- bus_wdata  out  32  lane-replicated store data.
- bus_gnt  in  1  request accepted this cycle.
- bus_rvalid  in  1  read data valid.
- bus_rdata  in  32  read data.
- bus_err  in  1  error, sampled with gnt (stores) or rvalid (loads).

Behaviour:
Reset values:
- State IDLE; all outputs 0.
- Asynchronous reset mid-access drops bus_req immediately and discards the transaction; no done is issued.

FSM states: IDLE, REQ, RESP, DONE.

IDLE:
- mem_read_write = req_valid & ~misalign (combinational).
- Misalign: H/HU with addr[0]=1, or W with addr[1:0]!=0.
- On valid & aligned:
  - Latch write, funct3, addr[1:0], rd and formatted wdata/wstrb.
  - Load bus outputs as registers.
  - Go to REQ.
- On valid & misaligned:
  - Pulse misaligned; no bus access; no stall; stay IDLE.

REQ:
- bus_req=1 and bus outputs stable until bus_gnt.
- On gnt:
  - Store: go to DONE; fault if bus_err.
  - Load: go to RESP.
- mem_read_write=1.

RESP:
- Wait for bus_rvalid.
- On rvalid, register the formatted bus_rdata into wb_data and go to DONE; fault if bus_err.
- mem_read_write=1.

DONE:
- mem_read_write=0; done=1.
- wb_reg_write=1 only for a fault-free load with rd!=0.
- fault pulses here.
- req_valid is ignored (EX/MEM holds a flushed bubble).
- Next state: IDLE.

Timing and limits:
- Timeout counter clears on entering REQ and counts REQ+RESP cycles. At TIMEOUT, go to DONE with fault=1 and wb_reg_write=0; a late rvalid is ignored.
- Minimum latency with zero-wait bus:
  - Load: 4 cycles, issue to DONE inclusive (gnt in first REQ cycle, rvalid in first RESP cycle).
  - Store: 3 cycles.
- Store formatting:
  - B: wstrb=0001<<lane, wdata=4x byte.
  - H: wstrb=0011<<lane, wdata=2x half.
  - W: wstrb=1111.
- Load formatting:
  - Select byte lane, or half lane by addr[1].
  - Sign-extend for B/H; zero-extend for BU/HU.
  - Any other funct3 is treated as W.
- Loads with rd=0 still access the bus.

Decomposition:
- Shared package holds:
  - funct3 width constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State enum.
  - Opcode constants LOAD=0000011 and STORE=0100011.
- One sub-module: lsu_load_format, purely combinational (rdata, lane, funct3 -> wb_data). It is reused by any future load path.

Test Plan:
- LW x5 from 0x100, gnt and rvalid immediate, rdata=0xDEADBEEF -> mem_read_write high for 3 cycles; DONE cycle has done=1, wb_rd=5, wb_data=0xDEADBEEF, wb_reg_write=1.
- LB from 0x103, rdata=0x80FF_0000 -> wb_data=0xFFFFFF80; LBU from the same address -> 0x00000080.
- SH data 0x1234ABCD to 0x202, gnt delayed 3 cycles -> bus_addr=0x200, wstrb=1100, wdata=0xABCDABCD held stable for the wait; done after gnt; wb_reg_write=0.
- LW from 0x101 -> misaligned pulses for 1 cycle; bus_req never rises; mem_read_write=0.
- Load with no rvalid, TIMEOUT=8 -> fault=1 and done=1 after 8 REQ+RESP cycles, wb_reg_write=0; a later rvalid is ignored, FSM in IDLE.
- rst_n low while in RESP -> bus_req, mem_read_write and done are 0 immediately; after release the next load completes normally.
